// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
// Build option FIR_SATURATE_EN: clamp the output instead of wrapping it.
package fir_pkg;

   localparam int FMT_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DONE
   } fir_state_e;

   function automatic int acc_width(input int dw, input int cw, input int taps);
      return dw + cw + $clog2(taps);
   endfunction

   // Reduce a sign-extended value to out_w bits; result stays sign-extended to FMT_W.
   function automatic logic signed [FMT_W-1:0] fit_width(input logic signed [FMT_W-1:0] y,
                                                         input int out_w);
      logic signed [FMT_W-1:0] res;
`ifdef FIR_SATURATE_EN
      logic signed [FMT_W-1:0] hi;
      logic signed [FMT_W-1:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (y > hi)      res = hi;
      else if (y < lo) res = lo;
      else             res = y;
`else
      res = (y <<< (FMT_W - out_w)) >>> (FMT_W - out_w);
`endif
      return res;
   endfunction

endpackage

// File: rtl/fir_tdm_filter_if.sv
// Sample, result and coefficient ports of fir_tdm_filter grouped as one bundle.
interface fir_tdm_filter_if #(
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int OUT_W = 24,
   parameter int TAPS  = 21
);
   logic                     in_valid;
   logic                     in_ready;
   logic [DW-1:0]            in_data;
   logic                     out_valid;
   logic [OUT_W-1:0]         out_data;
   logic                     coef_valid;
   logic                     coef_ready;
   logic [CW-1:0]            coef_data;
   logic [$clog2(TAPS)-1:0]  coef_rd_idx;
   logic [CW-1:0]            coef_rd_data;

   modport master (
      output in_valid, in_data, coef_valid, coef_data, coef_rd_idx,
      input  in_ready, out_valid, out_data, coef_ready, coef_rd_data
   );

   modport slave (
      input  in_valid, in_data, coef_valid, coef_data, coef_rd_idx,
      output in_ready, out_valid, out_data, coef_ready, coef_rd_data
   );
endinterface

// File: rtl/fir_mac.sv
// Single signed multiply-accumulate; acc_next exposes the value the register takes next edge.
module fir_mac #(
   parameter int DW   = 16,
   parameter int CW   = 16,
   parameter int ACCW = 35
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic                   en,
   input  logic signed [DW-1:0]   a,
   input  logic signed [CW-1:0]   b,
   output logic signed [ACCW-1:0] acc_next
);
   logic signed [DW+CW-1:0] prod;
   logic signed [ACCW-1:0]  acc_q, acc_d;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      prod  = a * b;
      acc_d = acc_q;
      if (clr)     acc_d = '0;
      else if (en) acc_d = acc_q + {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};
   end

   assign acc_next = acc_d;

   // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end
endmodule

// File: rtl/fir_tdm_filter.sv
// Time-multiplexed signed FIR: one multiplier walks TAPS products per accepted sample.
// Output reduction depends on FIR_SATURATE_EN (see fir_pkg::fit_width).
module fir_tdm_filter
   import fir_pkg::*;
#(
   parameter int TAPS  = 21,
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int OUT_W = 24,
   parameter int SHIFT = 8
) (
   input logic             clk,
   input logic             reset,
   fir_tdm_filter_if.slave bus
);
   localparam int ACCW = acc_width(DW, CW, TAPS);
   localparam int PW   = $clog2(TAPS);

   fir_state_e            state_q, state_d;
   logic [PW-1:0]         wp_q, wp_d, k_q, k_d, rd_idx;
   logic signed [DW-1:0]  dl_q [TAPS];
   logic signed [DW-1:0]  dl_d [TAPS];
   logic signed [CW-1:0]  coef_q [TAPS];
   logic signed [CW-1:0]  coef_d [TAPS];
   logic                  out_valid_q, out_valid_d;
   logic [OUT_W-1:0]      out_data_q, out_data_d;
   logic                  mac_clr, mac_en;
   logic signed [ACCW-1:0]  acc_next;
   logic signed [FMT_W-1:0] acc_ext, y_fit;

   // x[n-k] lives at (wp-k) mod TAPS; the wrap branch is exact modulo 2^PW.
   always_comb begin
      rd_idx = (wp_q >= k_q) ? wp_q - k_q : wp_q + PW'(TAPS) - k_q;
   end

   fir_mac #(.DW(DW), .CW(CW), .ACCW(ACCW)) u_mac (
      .clk      (clk),
      .reset    (reset),
      .clr      (mac_clr),
      .en       (mac_en),
      .a        (dl_q[rd_idx]),
      .b        (coef_q[k_q]),
      .acc_next (acc_next)
   );

   always_comb begin
      acc_ext = {{(FMT_W-ACCW){acc_next[ACCW-1]}}, acc_next};
      y_fit   = fit_width(acc_ext >>> SHIFT, OUT_W);
   end

   always_comb begin
      state_d        = state_q;
      wp_d           = wp_q;
      k_d            = k_q;
      dl_d           = dl_q;
      coef_d         = coef_q;
      out_valid_d    = 1'b0;
      out_data_d     = out_data_q;
      mac_clr        = 1'b0;
      mac_en         = 1'b0;
      bus.in_ready   = 1'b0;
      bus.coef_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.in_ready   = 1'b1;
            bus.coef_ready = 1'b1;
            if (bus.coef_valid) begin
               for (int i = TAPS - 1; i > 0; i--) coef_d[i] = coef_q[i-1];
               coef_d[0] = signed'(bus.coef_data);
            end
            if (bus.in_valid) begin
               dl_d[wp_q] = signed'(bus.in_data);
               mac_clr    = 1'b1;
               k_d        = '0;
               state_d    = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            k_d    = k_q + PW'(1);
            // Register the result on the last product so it is valid throughout DONE.
            if (k_q == PW'(TAPS - 1)) begin
               out_valid_d = 1'b1;
               out_data_d  = OUT_W'(y_fit);
               state_d     = DONE;
            end
         end
         DONE: begin
            wp_d    = (wp_q == PW'(TAPS - 1)) ? '0 : wp_q + PW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.coef_rd_data = '0;
      if (int'(bus.coef_rd_idx) < TAPS) bus.coef_rd_data = coef_q[bus.coef_rd_idx];
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // NOTE: delay line and coefficients are flops, so they must be cleared on reset like any state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wp_q        <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         dl_q        <= '{default: '0};
         coef_q      <= '{default: '0};
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         dl_q        <= dl_d;
         coef_q      <= coef_d;
      end
   end
endmodule

// File: tb/tb_fir_tdm_filter.sv
// Scoreboard bench for fir_tdm_filter (TAPS=5, SHIFT=0): stimulus pushes expected results, a monitor pops them.
module tb_fir_tdm_filter;
   localparam int TAPS  = 5;
   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int OUT_W = 24;
   localparam int SHIFT = 0;
   localparam int LAT   = TAPS + 1;
   localparam int PW    = $clog2(TAPS);

   typedef struct {
      logic [OUT_W-1:0] data;
      int               cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [OUT_W-1:0] big_exp [1:5];

   fir_tdm_filter_if #(.DW(DW), .CW(CW), .OUT_W(OUT_W), .TAPS(TAPS)) bus ();

   fir_tdm_filter #(
      .TAPS(TAPS), .DW(DW), .CW(CW), .OUT_W(OUT_W), .SHIFT(SHIFT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (!reset && bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 64'(bus.out_valid), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_data", 64'(bus.out_data), 64'(mon_e.data));
            check("out_latency", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   task automatic wait_ready(input bit coef_side, input string name);
      int t = 0;
      while ((coef_side ? bus.coef_ready : bus.in_ready) !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t == 200) check(name, 64'(coef_side ? bus.coef_ready : bus.in_ready), 64'd1);
   endtask

   task automatic coef_write(input logic [CW-1:0] d);
      @(negedge clk);
      wait_ready(1'b1, "coef_ready_timeout");
      bus.coef_valid = 1'b1;
      bus.coef_data  = d;
      @(negedge clk);
      bus.coef_valid = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] x, input logic [OUT_W-1:0] exp, input bit push,
                       input bit with_coef = 1'b0, input logic [CW-1:0] c = '0);
      @(negedge clk);
      wait_ready(1'b0, "in_ready_timeout");
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      if (with_coef) begin
         bus.coef_valid = 1'b1;
         bus.coef_data  = c;
      end
      if (push) exp_q.push_back('{data: exp, cyc: cyc + LAT});
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.coef_valid = 1'b0;
   endtask

   task automatic rd_check(input string name, input int idx, input logic [CW-1:0] exp);
      bus.coef_rd_idx = idx[PW-1:0];
      #1;
      check(name, 64'(bus.coef_rd_data), 64'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int accepts;
`ifdef FIR_SATURATE_EN
      for (int i = 1; i <= 5; i++) big_exp[i] = 24'h7FFFFF;
`else
      big_exp[1] = 24'hFF0001;
      big_exp[2] = 24'hFE0002;
      big_exp[3] = 24'hFD0003;
      big_exp[4] = 24'hFC0004;
      big_exp[5] = 24'hFB0005;
`endif
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      bus.coef_valid  = 1'b0;
      bus.coef_data   = '0;
      bus.coef_rd_idx = '0;

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_in_ready",   64'(bus.in_ready),   64'd1);
      check("rst_coef_ready", 64'(bus.coef_ready), 64'd1);
      check("rst_out_valid",  64'(bus.out_valid),  64'd0);
      check("rst_out_data",   64'(bus.out_data),   64'd0);
      rd_check("rst_coef0", 0, 16'h0000);

      // Impulse response: c[0..4] = 1..5
      coef_write(16'd5); coef_write(16'd4); coef_write(16'd3);
      coef_write(16'd2); coef_write(16'd1);
      rd_check("imp_coef0", 0, 16'd1);
      rd_check("imp_coef4", 4, 16'd5);
      rd_check("coef_oob",  7, 16'd0);
      send(16'd1, 24'd1, 1'b1);
      send(16'd0, 24'd2, 1'b1);
      send(16'd0, 24'd3, 1'b1);
      send(16'd0, 24'd4, 1'b1);
      send(16'd0, 24'd5, 1'b1);

      // Coefficient write while busy is dropped
      send(16'd0, 24'd0, 1'b1);
      bus.coef_valid = 1'b1;
      bus.coef_data  = 16'h1234;
      #1;
      check("busy_coef_ready", 64'(bus.coef_ready), 64'd0);
      check("busy_in_ready",   64'(bus.in_ready),   64'd0);
      @(negedge clk);
      check("busy_coef_ready2", 64'(bus.coef_ready), 64'd0);
      @(negedge clk);
      bus.coef_valid = 1'b0;
      rd_check("busy_coef0", 0, 16'd1);
      rd_check("busy_coef1", 1, 16'd2);

      // Simultaneous sample and coefficient write: c becomes {7,1,2,3,4}
      send(16'd1, 24'd7, 1'b1, 1'b1, 16'd7);
      rd_check("simul_coef0", 0, 16'd7);
      rd_check("simul_coef1", 1, 16'd1);

      // Signed: c = -1, x = -32768 (history still holds the previous 1)
      repeat (5) coef_write(16'hFFFF);
      send(16'h8000, 24'd32767,  1'b1);
      send(16'h8000, 24'd65535,  1'b1);
      send(16'h8000, 24'd98303,  1'b1);
      send(16'h8000, 24'd131071, 1'b1);
      send(16'h8000, 24'd163840, 1'b1);

      // Reset in MAC cycle 3 aborts the computation
      send(16'd1234, 24'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_in_ready",  64'(bus.in_ready),  64'd1);
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_out_data",  64'(bus.out_data),  64'd0);
      rd_check("abort_coef0", 0, 16'd0);
      rd_check("abort_coef2", 2, 16'd0);
      repeat (TAPS + 3) @(negedge clk);

      // Large products: output saturates or wraps depending on build
      repeat (5) coef_write(16'h7FFF);
      rd_check("sat_coef4", 4, 16'h7FFF);
      for (int i = 1; i <= 5; i++) send(16'h7FFF, big_exp[i], 1'b1);

      // Backpressure: in_valid held high, one accept every TAPS+2 cycles
      @(negedge clk);
      wait_ready(1'b0, "bp_start_timeout");
      bus.in_valid = 1'b1;
      bus.in_data  = '0;
      accepts = 0;
      for (int i = 0; i < 3 * (TAPS + 2); i++) begin
         check("bp_in_ready", 64'(bus.in_ready), 64'((i % (TAPS + 2)) == 0));
         if (bus.in_ready === 1'b1) begin
            accepts++;
            if (accepts <= 3) exp_q.push_back('{data: big_exp[5 - accepts], cyc: cyc + LAT});
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("bp_accepts", 64'(accepts), 64'd3);

      // Readback of a freshly written word
      coef_write(16'hAAAA);
      rd_check("rb_coef0", 0, 16'hAAAA);
      rd_check("rb_coef1", 1, 16'h7FFF);

      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
